// File: rtl/fpt_swarm_pkg.sv
// Shared constants and types for the swarm relay command link:
// frame layout, parser states and error encodings.
package fpt_swarm_pkg;

    localparam logic [7:0]  SyncByte = 8'hA5;
    localparam int unsigned FrameLen = 5;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrFraming  = 2'b01;
    localparam logic [1:0] ErrChecksum = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    // Encoded as the byte position within the frame.
    typedef enum logic [2:0] {
        StHunt = 3'd0,
        StCmd  = 3'd1,
        StDhi  = 3'd2,
        StDlo  = 3'd3,
        StCsum = 3'd4
    } parser_state_e;

endpackage

// File: rtl/swarm_uart_byte_rx.sv
// 8N1 serial-to-byte receiver: synchronizes the line, validates the start bit
// at half-bit, samples data and stop bits at mid-bit.
module swarm_uart_byte_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    logic            sync1_q, rx_s_q, rx_prev_q;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line still low one bit after a bad stop is a held break:
                // treat that instant as a validated start so breaks repeat every 10 bits.
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign byte_ferr  = ferr_q;

endmodule

// File: rtl/swarm_uart_rx.sv
// Swarm relay command receiver: frames A5/CMD/DHI/DLO/CSUM bytes from the
// UART, checks the xor checksum and enforces an inter-byte timeout.
module swarm_uart_rx #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [15:0] motor_command,
    output logic [7:0]  cmd_id,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        rx_busy
);
    import fpt_swarm_pkg::*;

    localparam int unsigned   ClksPerBit = CLK_HZ / BAUD;
    localparam logic [31:0]   TmoMax     = 32'(TIMEOUT_BITS * ClksPerBit);
    localparam parser_state_e LastState  = parser_state_e'(3'(FrameLen - 1));

    logic [7:0]    byte_data;
    logic          byte_valid, byte_ferr;
    parser_state_e state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [15:0]   motor_d;
    logic [7:0]    id_d;
    logic          valid_d, ferr_d;
    logic [1:0]    code_d;

    swarm_uart_byte_rx #(
        .CLKS_PER_BIT(ClksPerBit)
    ) u_byte_rx (
        .clk       (clk_100mhz),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ferr (byte_ferr)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        dhi_d   = dhi_q;
        dlo_d   = dlo_q;
        motor_d = motor_command;
        id_d    = cmd_id;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        code_d  = err_code;

        if (state_q == StHunt || byte_valid || byte_ferr) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + 32'd1;
        end else begin
            tmo_d = tmo_q;
        end

        // Byte completion is checked before the timeout so it wins a tie.
        if (byte_ferr) begin
            state_d = StHunt;
            ferr_d  = 1'b1;
            code_d  = ErrFraming;
        end else if (byte_valid) begin
            unique case (state_q)
                StHunt: if (byte_data == SyncByte) state_d = StCmd;
                StCmd: begin
                    cmd_d   = byte_data;
                    state_d = StDhi;
                end
                StDhi: begin
                    dhi_d   = byte_data;
                    state_d = StDlo;
                end
                StDlo: begin
                    dlo_d   = byte_data;
                    state_d = LastState;
                end
                LastState: begin
                    state_d = StHunt;
                    if (byte_data == (cmd_q ^ dhi_q ^ dlo_q)) begin
                        motor_d = {dhi_q, dlo_q};
                        id_d    = cmd_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        code_d = ErrChecksum;
                    end
                end
                default: state_d = StHunt;
            endcase
        end else if (state_q != StHunt && tmo_q == TmoMax) begin
            state_d = StHunt;
            ferr_d  = 1'b1;
            code_d  = ErrTimeout;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            cmd_q         <= '0;
            dhi_q         <= '0;
            dlo_q         <= '0;
            tmo_q         <= '0;
            motor_command <= '0;
            cmd_id        <= '0;
            cmd_valid     <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= ErrNone;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            dhi_q         <= dhi_d;
            dlo_q         <= dlo_d;
            tmo_q         <= tmo_d;
            motor_command <= motor_d;
            cmd_id        <= id_d;
            cmd_valid     <= valid_d;
            frame_err     <= ferr_d;
            err_code      <= code_d;
        end
    end

    assign rx_busy = (state_q != StHunt);

endmodule

// File: tb/tb_swarm_uart_rx.sv
// Directed bench for swarm_uart_rx: serial frames in, scoreboard of expected
// commands and error codes popped as the DUT pulses cmd_valid / frame_err.
module tb_swarm_uart_rx;

    localparam int unsigned CLK_HZ       = 3_210_000;
    localparam int unsigned BAUD         = 100_000;
    localparam int unsigned TIMEOUT_BITS = 32;
    localparam int unsigned CPB          = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] motor_command;
    logic [7:0]  cmd_id;
    logic        cmd_valid, frame_err, rx_busy;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int overlap = 0;
    logic [23:0] exp_cmd_q[$];
    logic [1:0]  exp_err_q[$];

    swarm_uart_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk_100mhz   (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .motor_command(motor_command),
        .cmd_id       (cmd_id),
        .cmd_valid    (cmd_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] ec;
        logic [1:0]  ee;
        if (cmd_valid && frame_err) overlap++;
        if (cmd_valid) begin
            n_valid++;
            ec = 'x;
            if (exp_cmd_q.size() != 0) ec = exp_cmd_q.pop_front();
            check("cmd_scoreboard", {8'h0, cmd_id, motor_command}, {8'h0, ec});
        end
        if (frame_err) begin
            n_err++;
            ee = 'x;
            if (exp_err_q.size() != 0) ee = exp_err_q.pop_front();
            check("err_scoreboard", {30'h0, err_code}, {30'h0, ee});
        end
    end

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(hi);
        send_byte(lo);
        send_byte(cs);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_motor"}, {16'h0, motor_command}, 32'h0);
        check({tag, "_id"}, {24'h0, cmd_id}, 32'h0);
        check({tag, "_valid"}, {31'h0, cmd_valid}, 32'h0);
        check({tag, "_ferr"}, {31'h0, frame_err}, 32'h0);
        check({tag, "_code"}, {30'h0, err_code}, 32'h0);
        check({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
    endtask

    initial begin
        int e0, v0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_bits(2);

        // Good frame
        exp_cmd_q.push_back({8'h12, 16'h03E8});
        send_frame(8'h12, 8'h03, 8'hE8, 8'hF9);
        idle_bits(1);
        check("good_motor", {16'h0, motor_command}, 32'h03E8);
        check("good_id", {24'h0, cmd_id}, 32'h12);
        check("good_nerr", n_err, 0);
        check("good_busy", {31'h0, rx_busy}, 32'h0);

        // Garbage, then a frame
        exp_cmd_q.push_back({8'h01, 16'h0005});
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h01, 8'h00, 8'h05, 8'h04);
        idle_bits(1);
        check("garbage_motor", {16'h0, motor_command}, 32'h0005);
        check("garbage_id", {24'h0, cmd_id}, 32'h01);
        check("garbage_nvalid", n_valid, 2);

        // Bad checksum keeps the previous command
        exp_err_q.push_back(2'b10);
        send_frame(8'h12, 8'h03, 8'hE8, 8'h00);
        idle_bits(1);
        check("csum_code", {30'h0, err_code}, 32'h2);
        check("csum_motor", {16'h0, motor_command}, 32'h0005);
        check("csum_id", {24'h0, cmd_id}, 32'h01);
        check("csum_nvalid", n_valid, 2);

        // Timeout mid-frame, then recovery
        send_byte(8'hA5);
        send_byte(8'h12);
        check("tmo_busy_before", {31'h0, rx_busy}, 32'h1);
        exp_err_q.push_back(2'b11);
        idle_bits(40);
        check("tmo_code", {30'h0, err_code}, 32'h3);
        check("tmo_busy_after", {31'h0, rx_busy}, 32'h0);
        exp_cmd_q.push_back({8'h34, 16'h1234});
        send_frame(8'h34, 8'h12, 8'h34, 8'h12);
        idle_bits(1);
        check("tmo_next_motor", {16'h0, motor_command}, 32'h1234);

        // Short glitch: nothing happens
        e0 = n_err;
        v0 = n_valid;
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        idle_bits(3);
        check("glitch_nerr", n_err, e0);
        check("glitch_nvalid", n_valid, v0);
        check("glitch_busy", {31'h0, rx_busy}, 32'h0);

        // Stop bit low while waiting for DHI
        send_byte(8'hA5);
        send_byte(8'h12);
        exp_err_q.push_back(2'b01);
        send_byte(8'h03, 1'b0);
        idle_bits(2);
        check("stop_code", {30'h0, err_code}, 32'h1);
        check("stop_busy", {31'h0, rx_busy}, 32'h0);

        // Break for 25 bit periods: framing errors at 9.5 and 19.5 bits
        e0 = n_err;
        v0 = n_valid;
        exp_err_q.push_back(2'b01);
        exp_err_q.push_back(2'b01);
        uart_rx = 1'b0;
        repeat (25 * CPB) @(negedge clk);
        idle_bits(12);
        check("break_nerr", n_err - e0, 2);
        check("break_nvalid", n_valid, v0);

        // Reset during DLO
        send_byte(8'hA5);
        send_byte(8'h77);
        send_byte(8'h03);
        uart_rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        idle_bits(2);
        exp_cmd_q.push_back({8'h56, 16'h00FF});
        send_frame(8'h56, 8'h00, 8'hFF, 8'hA9);
        idle_bits(1);
        check("post_reset_motor", {16'h0, motor_command}, 32'h00FF);
        check("post_reset_id", {24'h0, cmd_id}, 32'h56);

        check("cmd_queue_left", exp_cmd_q.size(), 0);
        check("err_queue_left", exp_err_q.size(), 0);
        check("valid_count", n_valid, 4);
        check("err_count", n_err, 5);
        check("valid_err_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swarm_uart_rx.md
SWARM_UART_RX -- requirements
Module: swarm_uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 The block SHALL have parameter TIMEOUT_BITS, default 32, giving the inter-byte gap limit in bit periods.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: port clk_100mhz, input, 1 bit, system clock.
REQ-005 Port rst_n SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-006 Port uart_rx SHALL be an input, 1 bit, asynchronous serial line from the nRF swarm relay; idles high.
REQ-007 Port motor_command SHALL be an output, 16 bits, holding the last good command payload.
REQ-008 Port cmd_id SHALL be an output, 8 bits, holding the last good command identifier.
REQ-009 Port cmd_valid SHALL be an output, 1 bit, pulsing high for one cycle per good frame.
REQ-010 Port frame_err SHALL be an output, 1 bit, pulsing high for one cycle per rejected frame.
REQ-011 Port err_code SHALL be an output, 2 bits: 01 = framing, 10 = checksum, 11 = timeout; it holds until the next error.
REQ-012 Port rx_busy SHALL be an output, 1 bit, high whenever the parser is not in HUNT.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 CLKS_PER_BIT SHALL be CLK_HZ/BAUD, using integer truncation (868 at the defaults).
REQ-015 Start detection:
- a high-to-low edge on the synchronized line SHALL arm the byte receiver;
- the line SHALL be re-sampled at CLKS_PER_BIT/2 (434);
- if the line is high there, the start is a glitch: return to idle with no error.
REQ-016 Data bits:
- 8 data bits SHALL be sampled at mid-bit, spaced CLKS_PER_BIT apart, LSB first.
REQ-017 Stop bit:
- the stop bit SHALL be sampled at mid-bit;
- low = framing error; the byte is discarded.
REQ-018 Frame format SHALL be 5 bytes in order: SYNC (0xA5), CMD, DHI, DLO, CSUM.
- CSUM = CMD xor DHI xor DLO.
REQ-019 The parser FSM SHALL have states HUNT, CMD, DHI, DLO, CSUM.
- HUNT -> CMD only on a received byte equal to 0xA5;
- any other byte in HUNT SHALL be dropped silently;
- each subsequent good byte SHALL advance one state;
- CSUM -> HUNT always.
REQ-020 A byte value of 0xA5 in CMD, DHI, DLO or CSUM SHALL be treated as data; there is no mid-frame resync.
REQ-021 On a CSUM match:
- motor_command SHALL load {DHI,DLO};
- cmd_id SHALL load CMD;
- cmd_valid SHALL pulse on the same cycle, one cycle after the CSUM stop-bit sample.
REQ-022 On a CSUM mismatch:
- motor_command and cmd_id SHALL be unchanged;
- frame_err SHALL pulse;
- err_code SHALL be set to 10.
REQ-023 A framing error in any non-HUNT state SHALL:
- return the FSM to HUNT;
- pulse frame_err;
- set err_code to 01.
REQ-024 A framing error in HUNT SHALL set err_code to 01 and pulse frame_err.
REQ-025 Timeout: in a non-HUNT state, if no byte completes within TIMEOUT_BITS*CLKS_PER_BIT cycles of the previous stop-bit sample, the block SHALL:
- return the FSM to HUNT;
- pulse frame_err;
- set err_code to 11.
REQ-026 The timeout counter SHALL saturate and SHALL clear on every completed byte.
REQ-027 If a timeout and a byte completion occur on the same cycle, byte completion SHALL win.
REQ-028 cmd_valid and frame_err SHALL never be high on the same cycle.
REQ-029 The line being held low (break) SHALL produce a framing error once per 10 bit periods, never a valid frame.

Reset
REQ-030 On rst_n low, all outputs SHALL be 0, the FSM SHALL be in HUNT, the byte receiver SHALL be idle, and the synchronizer flops SHALL be 1.
REQ-031 Reset asserted mid-frame SHALL discard all partial state; the first frame accepted after release SHALL begin with a fresh start bit.

Structure
REQ-032 Package fpt_swarm_pkg SHALL hold:
- the SYNC byte constant 0xA5;
- the parser state enum;
- the err_code encodings;
- the frame length constant 5.
REQ-033 The serial-to-byte receiver SHALL be a separate sub-module, swarm_uart_byte_rx:
- outputs byte_data[7:0], byte_valid pulse, byte_ferr pulse;
- the parser, checksum and timeout logic live in swarm_uart_rx.

Verification
REQ-034 Scenario, good frame: send A5 12 03 E8 F9 at 115200 -> one cmd_valid pulse, motor_command=0x03E8, cmd_id=0x12, frame_err never high.
REQ-035 Scenario, bad checksum: send A5 12 03 E8 00 -> frame_err pulse, err_code=10, motor_command unchanged from its prior value.
REQ-036 Scenario, garbage then frame: send 00 FF A5 01 00 05 04 -> only the last 5 bytes are accepted; motor_command=0x0005, cmd_id=0x01.
REQ-037 Scenario, timeout: send A5 12, then hold the line idle 40 bit periods -> frame_err with err_code=11, rx_busy low; a following good frame is accepted.
REQ-038 Scenario, glitch and stop error: a 100-cycle low glitch -> no byte, no error; a byte with stop bit 0 during DHI -> frame_err, err_code=01, FSM in HUNT.
REQ-039 Scenario, reset mid-frame: assert rst_n low during DLO -> all outputs 0; the next full good frame produces exactly one cmd_valid.
